reg_dump: RTL and testbench

REG_DUMP -- requirements
Module: reg_dump

---
 rtl/reg_dump_pkg.sv | 25 ++
 rtl/reg_dump_byte_serializer.sv | 39 +++
 rtl/reg_dump.sv | 112 +++++++++++
 tb/tb_reg_dump.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register dump engine: FSM state encoding and
// byte-per-register sizing helpers.
package reg_dump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_W = 32;

    function automatic int bytes_per_reg(input int data_w);
        return data_w / 8;
    endfunction

    localparam int BYTES_PER_REG = bytes_per_reg(DEFAULT_DATA_W);

    // Counter width that stays at least one bit even for a single-entry range.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_dump_byte_serializer.sv
// Holds one register word and hands it out a byte at a time, LSB first.
// last flags the final byte of the word currently held.
module reg_dump_byte_serializer
    import reg_dump_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    input  logic              advance,
    output logic [7:0]        tx_byte,
    output logic              last
);

    localparam int BPR   = bytes_per_reg(DATA_W);
    localparam int CNT_W = cnt_width(BPR);

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_byte_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift    <= '0;
            r_byte_cnt <= '0;
        end else if (load) begin
            r_shift    <= data;
            r_byte_cnt <= '0;
        end else if (advance && !last) begin
            r_shift    <= r_shift >> 8;
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
        end
    end

    assign tx_byte = r_shift[7:0];
    assign last    = (r_byte_cnt == CNT_W'(BPR - 1));

endmodule

// File: rtl/reg_dump.sv
// Walks registers 0..NUM_REGS-1 through the read port and streams each one
// out over a valid/ready byte interface, least-significant byte first.
//
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | rd_addr = idx, capture rd_data into the serializer
//   SEND  | present bytes of the captured word until the last one transfers
//   DONE  | one-cycle done pulse, then back to IDLE
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    output logic [$clog2(NUM_REGS)-1:0] rd_addr,
    input  logic [DATA_W-1:0]           rd_data,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int IDX_W = $clog2(NUM_REGS);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_load;
    logic             w_advance;
    logic             w_last;
    logic [7:0]       w_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // abort is checked before tx_ready so a cancelled byte never counts as sent.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (tx_ready) begin
                    w_advance = 1'b1;
                    if (w_last) begin
                        if (r_idx == IDX_W'(NUM_REGS - 1)) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_idx_nxt   = r_idx + IDX_W'(1);
                            w_state_nxt = ST_LOAD;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    reg_dump_byte_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk     (clk),
        .reset   (reset),
        .load    (w_load),
        .data    (rd_data),
        .advance (w_advance),
        .tx_byte (w_byte),
        .last    (w_last)
    );

    assign rd_addr  = r_idx;
    assign tx_valid = (r_state == ST_SEND);
    assign tx_data  = (r_state == ST_SEND) ? w_byte : 8'h00;
    assign busy     = (r_state == ST_LOAD) || (r_state == ST_SEND);
    assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: expected byte streams are queued from a
// register-file model and popped by monitors on every accepted byte.
module tb_reg_dump;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start0, abort0, ready0;
    logic [4:0]  rd_addr0;
    logic [31:0] rd_data0;
    logic [7:0]  tx_data0;
    logic        tx_valid0, busy0, done0;

    logic        start1, abort1, ready1;
    logic [1:0]  rd_addr1;
    logic [15:0] rd_data1;
    logic [7:0]  tx_data1;
    logic        tx_valid1, busy1, done1;

    logic [31:0] regs0 [32];
    logic [15:0] regs1 [4];
    assign rd_data0 = regs0[rd_addr0];
    assign rd_data1 = regs1[rd_addr1];

    reg_dump u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .rd_addr(rd_addr0), .rd_data(rd_data0), .tx_data(tx_data0),
        .tx_valid(tx_valid0), .tx_ready(ready0), .busy(busy0), .done(done0)
    );

    reg_dump #(.NUM_REGS(4), .DATA_W(16)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .tx_data(tx_data1),
        .tx_valid(tx_valid1), .tx_ready(ready1), .busy(busy1), .done(done1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp0_q [$];
    logic [7:0] rx0_q  [$];
    logic [7:0] exp1_q [$];
    int n_bytes0, done_cnt0, done_cyc0;
    int n_bytes1, done_cnt1, done_cyc1;
    int load_cyc;
    logic       prev_stall0;
    logic [7:0] prev_data0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference stream: every register, bytes least-significant first.
    task automatic push_dump0();
        for (int i = 0; i < 32; i++)
            for (int b = 0; b < 4; b++)
                exp0_q.push_back(8'((regs0[i] >> (8 * b)) & 32'hFF));
    endtask

    task automatic clear0();
        exp0_q.delete();
        rx0_q.delete();
        n_bytes0  = 0;
        done_cnt0 = 0;
        done_cyc0 = 0;
    endtask

    task automatic start_dump0();
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        load_cyc = cyc;
        check("load_busy", busy0, 1);
        check("load_valid", tx_valid0, 0);
        check("load_addr", rd_addr0, 0);
        @(posedge clk); #1;
        check("first_valid", tx_valid0, 1);
    endtask

    task automatic wait_done0(input int budget);
        int t = 0;
        while (done_cnt0 < 1 && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        check("dump_done_seen", done_cnt0, 1);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall0 = 1'b0;
        end else begin
            if (prev_stall0) begin
                check("stall_valid", tx_valid0, 1);
                check("stall_data", tx_data0, prev_data0);
            end
            if (tx_valid0 && ready0 && !abort0) begin
                n_bytes0++;
                rx0_q.push_back(tx_data0);
                if (exp0_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL byte0_extra: got 0x%0h, expected no byte", tx_data0);
                end else begin
                    check("byte0", tx_data0, exp0_q.pop_front());
                end
            end
            if (done0) begin
                done_cnt0++;
                done_cyc0 = cyc;
            end
            prev_stall0 = tx_valid0 && !ready0;
            prev_data0  = tx_data0;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (tx_valid1 && ready1) begin
                n_bytes1++;
                if (exp1_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL byte1_extra: got 0x%0h, expected no byte", tx_data1);
                end else begin
                    check("byte1", tx_data1, exp1_q.pop_front());
                end
            end
            if (done1) begin
                done_cnt1++;
                done_cyc1 = cyc;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
        $fatal(1);
    end

    initial begin
        logic [7:0] first8 [8];
        logic [7:0] beef   [4];
        int t;
        first8 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00};
        beef   = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

        reset = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; ready0 = 1'b1;
        start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
        n_bytes1 = 0; done_cnt1 = 0; done_cyc1 = 0;
        clear0();
        for (int i = 0; i < 32; i++) regs0[i] = 32'(32'h0000_0100 * i + i);

        repeat (3) @(posedge clk); #1;
        check("rst_valid", tx_valid0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_data", tx_data0, 0);
        check("rst_addr", rd_addr0, 0);
        reset = 1'b1;

        // Full dump, ready always high.
        clear0(); push_dump0();
        start_dump0();
        wait_done0(400);
        check("dump1_done_cycle", done_cyc0 - load_cyc, 160);
        check("dump1_bytes", n_bytes0, 128);
        check("dump1_leftover", exp0_q.size(), 0);
        for (int i = 0; i < 8; i++) check("dump1_first8", rx0_q[i], first8[i]);
        @(posedge clk); #1;
        check("done_one_cycle", done0, 0);
        check("idle_busy", busy0, 0);

        // Random backpressure.
        regs0[5] = 32'hDEADBEEF;
        clear0(); push_dump0();
        start_dump0();
        t = 0;
        while (done_cnt0 < 1 && t < 3000) begin
            @(posedge clk); #1;
            ready0 = ($urandom_range(0, 3) != 0);
            t++;
        end
        ready0 = 1'b1;
        check("dump2_done_seen", done_cnt0, 1);
        check("dump2_bytes", n_bytes0, 128);
        check("dump2_leftover", exp0_q.size(), 0);
        for (int i = 0; i < 4; i++) check("dump2_reg5", rx0_q[20 + i], beef[i]);

        // Abort while byte 2 of register 10 is on the bus.
        repeat (3) @(posedge clk);
        clear0(); push_dump0();
        start_dump0();
        t = 0;
        while (n_bytes0 < 42 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("abort_reach", n_bytes0, 42);
        check("abort_addr", rd_addr0, 10);
        check("abort_valid_before", tx_valid0, 1);
        abort0 = 1'b1;
        @(posedge clk); #1 abort0 = 1'b0;
        check("abort_valid", tx_valid0, 0);
        check("abort_busy", busy0, 0);
        check("abort_done", done0, 0);
        repeat (5) @(posedge clk); #1;
        check("abort_no_done", done_cnt0, 0);
        check("abort_bytes", n_bytes0, 42);
        clear0(); push_dump0();
        start_dump0();
        wait_done0(400);
        check("restart_bytes", n_bytes0, 128);
        check("restart_leftover", exp0_q.size(), 0);

        // Start pulses while busy must be ignored.
        clear0(); push_dump0();
        start_dump0();
        t = 0;
        while (done_cnt0 < 1 && t < 400) begin
            @(posedge clk); #1;
            start0 = 1'b0;
            if (busy0 && $urandom_range(0, 3) == 0) start0 = 1'b1;
            t++;
        end
        start0 = 1'b0;
        check("busy_start_done", done_cnt0, 1);
        repeat (10) @(posedge clk); #1;
        check("busy_start_no_restart", busy0, 0);
        check("busy_start_bytes", n_bytes0, 128);
        check("busy_start_done_cnt", done_cnt0, 1);

        // Asynchronous reset in the middle of SEND.
        clear0(); push_dump0();
        start_dump0();
        repeat (20) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("arst_valid", tx_valid0, 0);
        check("arst_busy", busy0, 0);
        check("arst_done", done0, 0);
        check("arst_data", tx_data0, 0);
        check("arst_addr", rd_addr0, 0);
        repeat (3) @(posedge clk); #1;
        check("arst_no_done", done_cnt0, 0);
        clear0(); push_dump0();
        @(posedge clk); #1;
        reset  = 1'b1;
        start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        load_cyc = cyc;
        check("post_rst_start", busy0, 1);
        wait_done0(400);
        check("post_rst_bytes", n_bytes0, 128);
        check("post_rst_done_cycle", done_cyc0 - load_cyc, 160);

        // Small configuration: 4 x 16-bit registers.
        for (int i = 0; i < 4; i++) regs1[i] = 16'($urandom);
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 2; b++)
                exp1_q.push_back(8'((regs1[i] >> (8 * b)) & 16'hFF));
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        load_cyc = cyc;
        t = 0;
        while (done_cnt1 < 1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("small_done_seen", done_cnt1, 1);
        check("small_done_cycle", done_cyc1 - load_cyc, 12);
        check("small_bytes", n_bytes1, 8);
        check("small_leftover", exp1_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
